// File: rtl/clkdiv_pkg.sv
// Shared constants and the configuration record for the programmable clock divider.
package clkdiv_pkg;

   localparam int MIN_DIV     = 2;
   localparam int CH_FIELD_W  = 4;
   localparam int DIV_FIELD_W = 32;

   typedef struct packed {
      logic [CH_FIELD_W-1:0]  ch;
      logic [DIV_FIELD_W-1:0] div;
   } div_cfg_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active/pending divide values and registered outputs.
module clkdiv_chan
   import clkdiv_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 10
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_en,
   input  logic                   i_cfg_we,
   input  logic [DIV_FIELD_W-1:0] i_cfg_div,
   output logic                   o_pending,
   output logic                   o_clkdiv,
   output logic                   o_tick
);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_div;
   logic [WIDTH-1:0] r_pend_div;
   logic             r_pend;
   logic             r_clkdiv;
   logic             r_tick;

   logic             w_wrap;
   logic [WIDTH-1:0] w_cfg_div;

   assign w_wrap    = (r_cnt == (r_div - WIDTH'(1)));
   assign w_cfg_div = (i_cfg_div < DIV_FIELD_W'(MIN_DIV)) ? WIDTH'(MIN_DIV)
                                                          : i_cfg_div[WIDTH-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_div      <= WIDTH'(DEFAULT_DIV);
         r_pend_div <= '0;
         r_pend     <= 1'b0;
         r_clkdiv   <= 1'b0;
         r_tick     <= 1'b0;
      end else begin
         r_tick <= 1'b0;
         if (i_en) begin
            r_clkdiv <= (r_cnt >= (r_div >> 1));
            if (w_wrap) begin
               r_cnt  <= '0;
               r_tick <= 1'b1;
               // New divide only takes effect at a period boundary
               if (r_pend) begin
                  r_div  <= r_pend_div;
                  r_pend <= 1'b0;
               end
            end else begin
               r_cnt <= r_cnt + WIDTH'(1);
            end
         end else if (r_pend) begin
            r_div  <= r_pend_div;
            r_pend <= 1'b0;
            r_cnt  <= '0;
         end
         if (i_cfg_we) begin
            r_pend_div <= w_cfg_div;
            r_pend     <= 1'b1;
         end
      end
   end

   assign o_pending = r_pend;
   assign o_clkdiv  = r_clkdiv;
   assign o_tick    = r_tick;

endmodule

// File: rtl/clkdiv_prog.sv
// Multi-channel programmable clock divider: config decode, ready mux and channel array.
module clkdiv_prog
   import clkdiv_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int WIDTH       = 16,
   parameter int DEFAULT_DIV = 10,
   localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [WIDTH-1:0]  cfg_div,
   output logic [N_CH-1:0]   clkdiv,
   output logic [N_CH-1:0]   tick
);

   div_cfg_t        w_cfg;
   logic [N_CH-1:0] w_pend;
   logic [N_CH-1:0] w_we;

   assign w_cfg.ch  = CH_FIELD_W'(cfg_ch);
   assign w_cfg.div = DIV_FIELD_W'(cfg_div);

   // Out-of-range channels match nothing, so they stay ready and are dropped
   always_comb begin
      cfg_ready = 1'b1;
      for (int i = 0; i < N_CH; i++) begin
         if (w_cfg.ch == CH_FIELD_W'(i)) cfg_ready = ~w_pend[i];
      end
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
         assign w_we[gi] = cfg_valid & cfg_ready & (w_cfg.ch == CH_FIELD_W'(gi));

         clkdiv_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
         ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .i_en      (en[gi]),
            .i_cfg_we  (w_we[gi]),
            .i_cfg_div (w_cfg.div),
            .o_pending (w_pend[gi]),
            .o_clkdiv  (clkdiv[gi]),
            .o_tick    (tick[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_clkdiv_prog.sv
// Directed table-driven bench for clkdiv_prog with hand-derived waveforms per phase.
module tb_clkdiv_prog;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  en = 4'hF;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [1:0]  cfg_ch = 2'd0;
   logic [15:0] cfg_div = 16'd0;
   logic [3:0]  clkdiv;
   logic [3:0]  tick;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  en;
      logic        valid;
      logic [1:0]  ch;
      logic [15:0] div;
      logic [3:0]  exp_clk;
      logic [3:0]  exp_tick;
      logic        exp_ready;
   } vec_t;

   vec_t vecs[$];

   clkdiv_prog #(.N_CH(4), .WIDTH(16), .DEFAULT_DIV(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_div   (cfg_div),
      .clkdiv    (clkdiv),
      .tick      (tick)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached (got timeout, required completion)");
      $fatal(1, "watchdog");
   end

   // Expected clkdiv / tick at k counts into a period of length p
   function automatic logic sc(int k, int p);
      return (k % p) >= (p / 2);
   endfunction

   function automatic logic st(int k, int p);
      return (k % p) == (p - 1);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic add(logic [3:0] e, logic v, logic [1:0] c, logic [15:0] d,
                      logic [3:0] xc, logic [3:0] xt, logic xr);
      vec_t t;
      t.en = e; t.valid = v; t.ch = c; t.div = d;
      t.exp_clk = xc; t.exp_tick = xt; t.exp_ready = xr;
      vecs.push_back(t);
   endtask

   task automatic apply(string tag);
      for (int i = 0; i < vecs.size(); i++) begin
         en        = vecs[i].en;
         cfg_valid = vecs[i].valid;
         cfg_ch    = vecs[i].ch;
         cfg_div   = vecs[i].div;
         #1;
         chk($sformatf("%s[%0d].ready", tag, i), 32'(cfg_ready), 32'(vecs[i].exp_ready));
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("%s[%0d].clkdiv", tag, i), 32'(clkdiv), 32'(vecs[i].exp_clk));
         chk($sformatf("%s[%0d].tick", tag, i), 32'(tick), 32'(vecs[i].exp_tick));
         $display("%s e=%0d en=%h cfg=%0d/%0d/%0d ready=%0d clkdiv=%h tick=%h",
                  tag, i, vecs[i].en, vecs[i].valid, vecs[i].ch, vecs[i].div,
                  cfg_ready, clkdiv, tick);
      end
      vecs.delete();
      en        = 4'hF;
      cfg_valid = 1'b0;
      cfg_ch    = 2'd0;
      cfg_div   = 16'd0;
   endtask

   task automatic do_reset(string tag);
      rst       = 1'b0;
      en        = 4'hF;
      cfg_valid = 1'b0;
      cfg_ch    = 2'd0;
      cfg_div   = 16'd0;
      @(negedge clk);
      @(negedge clk);
      chk({tag, ".rst_clkdiv"}, 32'(clkdiv), 32'h0);
      chk({tag, ".rst_tick"}, 32'(tick), 32'h0);
      chk({tag, ".rst_ready"}, 32'(cfg_ready), 32'h1);
      rst = 1'b1;
   endtask

   initial begin
      logic s, c0, c1, c2, c3, t0, t1, t2, t3, v, r;
      logic [1:0]  ch;
      logic [3:0]  e4;
      logic [15:0] d;

      // A: default divide of 10 on every channel after reset release
      do_reset("A");
      for (int e = 0; e < 20; e++)
         add(4'hF, 1'b0, 2'd0, 16'd0, {4{sc(e, 10)}}, {4{st(e, 10)}}, 1'b1);
      apply("A");

      // B: ch1 gets 4 mid-period, then 6 is held off until the wrap
      do_reset("B");
      for (int e = 0; e < 24; e++) begin
         s = sc(e, 10);
         t0 = st(e, 10);
         v = (e >= 3 && e <= 10);
         d = (e == 3) ? 16'd4 : (v ? 16'd6 : 16'd0);
         if (e < 10)      begin c1 = sc(e, 10);      t1 = st(e, 10);      end
         else if (e < 14) begin c1 = sc(e - 10, 4);  t1 = st(e - 10, 4);  end
         else             begin c1 = sc(e - 14, 6);  t1 = st(e - 14, 6);  end
         r = (e <= 3) || (e == 10) || (e >= 14);
         add(4'hF, v, 2'd1, d, {s, s, c1, s}, {t0, t0, t1, t0}, r);
      end
      apply("B");

      // C: clamp of 1 and 0 to 2; ch2 write lands on its wrap cycle
      do_reset("C");
      for (int e = 0; e < 26; e++) begin
         s = sc(e, 10);
         t0 = st(e, 10);
         v  = (e == 2) || (e == 9);
         ch = (e == 2) ? 2'd3 : ((e == 9) ? 2'd2 : 2'd0);
         d  = (e == 2) ? 16'd1 : 16'd0;
         if (e < 10) begin c3 = s; t3 = t0; end
         else        begin c3 = sc(e - 10, 2); t3 = st(e - 10, 2); end
         if (e < 20) begin c2 = s; t2 = t0; end
         else        begin c2 = sc(e - 20, 2); t2 = st(e - 20, 2); end
         add(4'hF, v, ch, d, {c3, c2, s, s}, {t3, t2, t0, t0}, 1'b1);
      end
      apply("C");

      // D: ch2 paused 7 cycles while high; ch0 paused with a pending write
      do_reset("D");
      for (int e = 0; e < 37; e++) begin
         s = sc(e, 10);
         t0 = st(e, 10);
         e4 = 4'hF;
         if (e >= 3 && e <= 5)   e4[0] = 1'b0;
         if (e >= 16 && e <= 22) e4[2] = 1'b0;
         if (e < 3)      begin c0 = s;    t0 = st(e, 10);    end
         else if (e < 6) begin c0 = 1'b0; t0 = 1'b0;         end
         else            begin c0 = sc(e - 6, 4); t0 = st(e - 6, 4); end
         if (e < 16)      begin c2 = s;    t2 = st(e, 10);    end
         else if (e < 23) begin c2 = 1'b1; t2 = 1'b0;         end
         else             begin c2 = sc(e - 7, 10); t2 = st(e - 7, 10); end
         add(e4, (e == 3), 2'd0, (e == 3) ? 16'd4 : 16'd0,
             {s, c2, s, c0}, {st(e, 10), t2, st(e, 10), t0}, (e != 4));
      end
      apply("D");

      // E: reset while ch0 has a pending write discards it
      do_reset("E");
      for (int e = 0; e < 10; e++)
         add(4'hF, (e == 9), 2'd0, (e == 9) ? 16'd4 : 16'd0,
             {4{sc(e, 10)}}, {4{st(e, 10)}}, 1'b1);
      apply("E");
      #1;
      chk("E.pending_ready", 32'(cfg_ready), 32'h0);
      rst = 1'b0;
      #1;
      chk("E.async_clkdiv", 32'(clkdiv), 32'h0);
      chk("E.async_tick", 32'(tick), 32'h0);
      chk("E.async_ready", 32'(cfg_ready), 32'h1);
      $display("E async reset: clkdiv=%h tick=%h ready=%0d", clkdiv, tick, cfg_ready);
      @(negedge clk);
      rst = 1'b1;
      for (int e = 0; e < 20; e++)
         add(4'hF, 1'b0, 2'd0, 16'd0, {4{sc(e, 10)}}, {4{st(e, 10)}}, 1'b1);
      apply("E2");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/clkdiv_prog.md
CLKDIV_PROG -- requirements
Module: clkdiv_prog

Interface
REQ-001 Parameter N_CH, default 4, number of independent divider channels (1..16).
REQ-002 Parameter WIDTH, default 16, width of each channel's divide value and counter.
REQ-003 Parameter DEFAULT_DIV, default 10, divide value loaded into every channel at reset (2..2^WIDTH-1).
REQ-004 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port en  input  N_CH  per-channel count enable.
REQ-007 Port cfg_valid  input  1  configuration request.
REQ-008 Port cfg_ready  output  1  configuration can be accepted for cfg_ch.
REQ-009 Port cfg_ch  input  max(1,$clog2(N_CH))  target channel index.
REQ-010 Port cfg_div  input  WIDTH  new divide value.
REQ-011 Port clkdiv  output  N_CH  registered divided clock per channel.
REQ-012 Port tick  output  N_CH  registered one-cycle pulse per channel period.

Function
REQ-013 Each channel SHALL hold a counter cnt, an active divide value div, a pending divide value, and a pending flag.
REQ-014 With en[i]=1, cnt SHALL increment each cycle and wrap to 0 after reaching div-1.
REQ-015 With en[i]=0, cnt, clkdiv[i] and div SHALL hold, and tick[i] SHALL be 0.
REQ-016 clkdiv[i] SHALL be registered: value at cycle t+1 = (cnt(t) >= div>>1) when en[i]=1 at t, giving a low phase of div>>1 counts.
REQ-017 tick[i] SHALL be 1 for exactly the cycle after cnt==div-1 with en[i]=1, and 0 otherwise.
REQ-018 A configuration transfer SHALL occur on a cycle with cfg_valid=1 and cfg_ready=1.
REQ-019 cfg_ready SHALL be combinational: 1 when cfg_ch's pending flag is clear or cfg_ch >= N_CH, else 0.
REQ-020 On transfer, the pending value SHALL be set to max(cfg_div,2) and the pending flag SHALL be set.
REQ-021 A transfer to cfg_ch >= N_CH SHALL be accepted and discarded with no state change.
REQ-022 If en[i]=1, the pending value SHALL become div on the wrap cycle (cnt==div-1 -> 0), and the pending flag SHALL clear in the same cycle.
REQ-023 If en[i]=0 while pending, the pending value SHALL become div on the next cycle, cnt SHALL be set to 0, and clkdiv[i] SHALL hold.
REQ-024 If a transfer and the wrap occur in the same cycle, the new value SHALL be pended and applied at the following wrap, never the same cycle.
REQ-025 Channels SHALL be fully independent; activity on one SHALL not alter timing of another.
REQ-026 cnt comparisons SHALL use WIDTH-bit unsigned arithmetic with no overflow, since cnt <= div-1 <= 2^WIDTH-2.
REQ-027 On a divide change, no clkdiv[i] phase shorter than min(old,new div)>>1 cycles SHALL be produced.

Reset
REQ-028 While rst=0, every channel SHALL have cnt=0, div=DEFAULT_DIV, pending flag clear, clkdiv=0 and tick=0, asynchronously.
REQ-029 A reset asserted during a pending configuration SHALL discard the pending value.
REQ-030 The first rising edge with rst=1 SHALL count as cycle 0 of the first period.

Structure
REQ-031 Package clkdiv_pkg SHALL hold the MIN_DIV=2 constant and a div_cfg_t struct typedef (channel, div).
REQ-032 Sub-module clkdiv_chan SHALL implement one channel (REQ-013..017, 020, 022..024) and be generated N_CH times.
REQ-033 The top SHALL contain only the cfg_ch decode, the cfg_ready mux and the channel instances.

Verification
REQ-034 Reset release, en=1, DEFAULT_DIV=10 -> per channel, clkdiv is 0 for 5 cycles then 1 for 5 cycles, repeating; tick pulses every 10 cycles.
REQ-035 Write cfg_div=4 to channel 1 mid-period -> current 10-cycle period completes, then period 4 (2 low/2 high); other channels are unchanged.
REQ-036 Second write to channel 1 while pending -> cfg_ready=0 until the wrap, then the second write is accepted.
REQ-037 cfg_div=0 and cfg_div=1 -> clamped to 2; clkdiv toggles every cycle and tick pulses every 2 cycles.
REQ-038 en[2]=0 for 7 cycles mid-period -> clkdiv[2] holds, tick[2]=0, and the count resumes from the held value.
REQ-039 rst asserted with a pending write on channel 0 -> all outputs 0 immediately; after release the period is 10, not the pended value.
